// File: rtl/ray_dispatch_scheduler.sv
// Frame controller for a bank of ray-generator cores: launches every core, merges their
// rays round-robin into one registered valid/ready stream and counts the frame out.
module ray_dispatch_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int CORE_W    = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [12:0]             image_width,
    input  logic [12:0]             image_height,
    output logic                    frame_busy,
    output logic                    frame_done,
    output logic [NUM_CORES-1:0]    core_en,
    input  logic [NUM_CORES-1:0]    core_valid,
    output logic [NUM_CORES-1:0]    core_ready,
    input  logic [32*NUM_CORES-1:0] core_ray_x,
    input  logic [32*NUM_CORES-1:0] core_ray_y,
    input  logic [32*NUM_CORES-1:0] core_ray_z,
    input  logic [32*NUM_CORES-1:0] core_index,
    output logic                    ray_valid,
    input  logic                    ray_ready,
    output logic [31:0]             ray_x,
    output logic [31:0]             ray_y,
    output logic [31:0]             ray_z,
    output logic [31:0]             ray_index,
    output logic [CORE_W-1:0]       ray_core
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

    localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_CORES - 1);

    state_t            state, state_next;
    logic [25:0]       total, issued, delivered, frame_size;
    logic [CORE_W-1:0] rr_ptr, grant_id;
    logic              grant_found, slot_free, handshake;
    logic [31:0]       sel_x, sel_y, sel_z, sel_index;

    assign frame_size = 26'(image_width) * 26'(image_height);
    assign slot_free  = !ray_valid || ray_ready;
    assign handshake  = ray_valid && ray_ready;
    assign frame_busy = (state != S_IDLE);
    assign frame_done = (state == S_DONE);
    assign core_en    = {NUM_CORES{state == S_LAUNCH}};

    // Grant the first valid core found at rr_ptr, rr_ptr+1, ... (mod NUM_CORES).
    // NOTE: every always_comb output is defaulted first, so no path can leave a latch behind.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        core_ready  = '0;
        sel_x       = '0;
        sel_y       = '0;
        sel_z       = '0;
        sel_index   = '0;
        if (state == S_RUN && slot_free && issued < total) begin
            for (int j = 0; j < NUM_CORES; j++) begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (!grant_found && core_valid[i] &&
                        i == (int'(rr_ptr) + j) % NUM_CORES) begin
                        grant_found   = 1'b1;
                        grant_id      = CORE_W'(i);
                        core_ready[i] = 1'b1;
                        sel_x         = core_ray_x[32*i +: 32];
                        sel_y         = core_ray_y[32*i +: 32];
                        sel_z         = core_ray_z[32*i +: 32];
                        sel_index     = core_index[32*i +: 32];
                    end
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = (frame_size == '0) ? S_DONE : S_LAUNCH;
            S_LAUNCH: state_next = S_RUN;
            S_RUN:    if (handshake && (delivered + 26'd1) == total) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            total     <= '0;
            issued    <= '0;
            delivered <= '0;
            rr_ptr    <= '0;
            ray_valid <= 1'b0;
            ray_x     <= '0;
            ray_y     <= '0;
            ray_z     <= '0;
            ray_index <= '0;
            ray_core  <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        total     <= frame_size;
                        issued    <= '0;
                        delivered <= '0;
                        rr_ptr    <= '0;
                    end
                end
                S_RUN: begin
                    if (handshake) delivered <= delivered + 26'd1;
                    // A grant in the same cycle as a handshake reloads the slot for full throughput.
                    if (grant_found) begin
                        ray_valid <= 1'b1;
                        ray_x     <= sel_x;
                        ray_y     <= sel_y;
                        ray_z     <= sel_z;
                        ray_index <= sel_index;
                        ray_core  <= grant_id;
                        issued    <= issued + 26'd1;
                        rr_ptr    <= (grant_id == LAST_CORE) ? '0 : grant_id + 1'b1;
                    end else if (handshake) begin
                        ray_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// Self-checking bench for ray_dispatch_scheduler: directed frames plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_ray_dispatch_scheduler;

    localparam int N  = 4;
    localparam int CW = 3;

    typedef enum {P_IDLE, P_LAUNCH, P_RUN, P_DONE} phase_e;

    logic            clk = 1'b0;
    logic            reset_n, start, ray_ready;
    logic [12:0]     w, h;
    logic            frame_busy, frame_done, ray_valid;
    logic [N-1:0]    core_en, core_valid, core_ready;
    logic [32*N-1:0] core_ray_x, core_ray_y, core_ray_z, core_index;
    logic [31:0]     ray_x, ray_y, ray_z, ray_index;
    logic [CW-1:0]   ray_core;
    logic [31:0]     cx[N], cy[N], cz[N], ci[N];

    ray_dispatch_scheduler #(.NUM_CORES(N), .CORE_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .image_width(w), .image_height(h),
        .frame_busy(frame_busy), .frame_done(frame_done), .core_en(core_en),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_ray_x(core_ray_x), .core_ray_y(core_ray_y), .core_ray_z(core_ray_z),
        .core_index(core_index),
        .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_x(ray_x), .ray_y(ray_y), .ray_z(ray_z), .ray_index(ray_index),
        .ray_core(ray_core)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            core_ray_x[32*i +: 32] = cx[i];
            core_ray_y[32*i +: 32] = cy[i];
            core_ray_z[32*i +: 32] = cz[i];
            core_index[32*i +: 32] = ci[i];
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: frame bookkeeping and the one-deep output slot.
    phase_e      m_phase;
    int          m_total, m_issued, m_delivered, m_ptr, m_core;
    bit          m_valid;
    logic [31:0] m_x, m_y, m_z, m_idx;

    // Stimulus controls and observations.
    int          mode, refresh_g, cyc;
    logic [N-1:0] fixed_valid, first_mask;
    bit          ready_fixed, ready_rand, chk_en;
    int          obs_log[$];
    int          obs_hs, obs_grants, obs_done, hs_first, hs_last, done_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_total = 0; m_issued = 0; m_delivered = 0; m_ptr = 0; m_core = 0;
        m_valid = 1'b0;
        m_x = '0; m_y = '0; m_z = '0; m_idx = '0;
    endtask

    function automatic int exp_grant();
        if (m_phase != P_RUN || (m_valid && !ray_ready) || m_issued >= m_total) return -1;
        for (int j = 0; j < N; j++) begin
            int idx = (m_ptr + j) % N;
            if (1'(core_valid >> idx)) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        int g;
        bit hs;
        if (!reset_n) begin
            model_reset();
            return;
        end
        g  = exp_grant();
        hs = m_valid && ray_ready;
        case (m_phase)
            P_IDLE: if (start) begin
                m_total = int'(w) * int'(h);
                m_issued = 0; m_delivered = 0; m_ptr = 0;
                m_phase = (m_total == 0) ? P_DONE : P_LAUNCH;
            end
            P_LAUNCH: m_phase = P_RUN;
            P_RUN: begin
                if (hs) m_delivered++;
                if (g >= 0) begin
                    m_x = cx[2'(g)]; m_y = cy[2'(g)]; m_z = cz[2'(g)]; m_idx = ci[2'(g)];
                    m_core = g; m_valid = 1'b1; m_issued++;
                    m_ptr = (g + 1) % N;
                    refresh_g = g;
                end else if (hs) begin
                    m_valid = 1'b0;
                end
                if (hs && m_delivered == m_total) m_phase = P_DONE;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic drive_inputs();
        if (refresh_g >= 0) begin
            cx[2'(refresh_g)] = $urandom; cy[2'(refresh_g)] = $urandom;
            cz[2'(refresh_g)] = $urandom; ci[2'(refresh_g)] = $urandom;
            refresh_g = -1;
        end
        case (mode)
            0:       core_valid = fixed_valid;
            1:       core_valid = 4'($urandom);
            default: core_valid = (m_issued == 0) ? first_mask : fixed_valid;
        endcase
        ray_ready = ready_rand ? 1'($urandom) : ready_fixed;
    endtask

    task automatic check_outputs();
        int g = exp_grant();
        logic [N-1:0] er = (g >= 0) ? 4'(1 << g) : 4'd0;
        check("core_ready", 64'(core_ready), 64'(er));
        check("frame_busy", 64'(frame_busy), 64'(m_phase != P_IDLE));
        check("frame_done", 64'(frame_done), 64'(m_phase == P_DONE));
        check("core_en", 64'(core_en), 64'((m_phase == P_LAUNCH) ? 4'hF : 4'h0));
        check("ray_valid", 64'(ray_valid), 64'(m_valid));
        check("ray_x", 64'(ray_x), 64'(m_x));
        check("ray_y", 64'(ray_y), 64'(m_y));
        check("ray_z", 64'(ray_z), 64'(m_z));
        check("ray_index", 64'(ray_index), 64'(m_idx));
        check("ray_core", 64'(ray_core), 64'(m_core));
        if (ray_valid && ray_ready) begin
            obs_log.push_back(int'(ray_core));
            obs_hs++;
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
        end
        if ((core_valid & core_ready) != '0) obs_grants++;
        if (frame_done) begin
            obs_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) check_outputs();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        drive_inputs();
    endtask

    task automatic clear_obs();
        obs_log.delete();
        obs_hs = 0; obs_grants = 0; obs_done = 0;
        hs_first = -1; hs_last = -1; done_cyc = -1;
    endtask

    task automatic run_frame(input int fw, input int fh, input int stall_at,
                             input int stall_len, input int restart_at);
        clear_obs();
        w = 13'(fw); h = 13'(fh); start = 1'b1;
        drive_inputs();
        cycle();
        start = 1'b0;
        for (int k = 0; k < 2000 && m_phase != P_IDLE; k++) begin
            start = 1'b0;
            if (k == stall_at) begin ready_fixed = 1'b0; drive_inputs(); end
            if (k == stall_at + stall_len) begin ready_fixed = 1'b1; drive_inputs(); end
            if (k == restart_at) begin start = 1'b1; w = 13'd7; h = 13'd7; end
            cycle();
        end
        start = 1'b0;
        check("frame_idle", 64'(frame_busy), 64'(0));
    endtask

    task automatic check_log(input string tag, input int n, input logic [31:0] seq);
        check({tag, "_len"}, 64'(obs_log.size()), 64'(n));
        for (int i = 0; i < n; i++)
            check(tag, 64'((i < obs_log.size()) ? obs_log[i] : -1), 64'(seq[4*i +: 4]));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            cx[i] = $urandom; cy[i] = $urandom; cz[i] = $urandom; ci[i] = $urandom;
        end
        model_reset();
        refresh_g = -1; cyc = 0; chk_en = 1'b0;
        mode = 0; fixed_valid = 4'hF; first_mask = 4'hF;
        ready_fixed = 1'b1; ready_rand = 1'b0;
        reset_n = 1'b0; start = 1'b0; w = 13'd2; h = 13'd2;
        clear_obs();
        drive_inputs();

        // Reset held three cycles with every core valid.
        cycle();
        chk_en = 1'b1;
        cycle();
        cycle();
        reset_n = 1'b1;

        // First frame 2x2: single-cycle launch pulse.
        run_frame(2, 2, -1, 0, -1);
        check("first_count", 64'(obs_hs), 64'(4));

        // Round-robin fairness over a 4x2 image.
        run_frame(4, 2, -1, 0, -1);
        check_log("fair_seq", 8, 32'h3210_3210);
        check("fair_consec", 64'(hs_last - hs_first), 64'(7));
        check("fair_done_lat", 64'(done_cyc - hs_last), 64'(1));

        // Backpressure: ray_ready low for 5 cycles mid-frame, 3x2 image.
        run_frame(3, 2, 3, 5, -1);
        check_log("bp_seq", 6, 32'h0010_3210);
        check("bp_grants", 64'(obs_grants), 64'(6));

        // Sparse valid: core 2 alone, then core 0.
        mode = 2; first_mask = 4'b0100; fixed_valid = 4'b0001;
        run_frame(2, 1, -1, 0, -1);
        check_log("sparse_seq", 2, 32'h0000_0002);

        // Pointer wrap: core 3 alone, then all cores; the search restarts at core 0.
        first_mask = 4'b1000; fixed_valid = 4'b1111;
        run_frame(2, 1, -1, 0, -1);
        check_log("wrap_seq", 2, 32'h0000_0003);
        mode = 0;

        // Over-supply: 1x3 image, all four cores valid.
        run_frame(1, 3, -1, 0, -1);
        check_log("over_seq", 3, 32'h0000_0210);
        check("over_grants", 64'(obs_grants), 64'(3));

        // Zero-area frame.
        run_frame(0, 5, -1, 0, -1);
        check("zero_grants", 64'(obs_grants), 64'(0));
        check("zero_done", 64'(obs_done), 64'(1));

        // start pulsed during RUN is ignored.
        run_frame(2, 2, -1, 0, 3);
        check("restart_count", 64'(obs_hs), 64'(4));

        // Reset asserted mid-RUN aborts the frame without frame_done.
        clear_obs();
        w = 13'd4; h = 13'd4; start = 1'b1;
        drive_inputs();
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        repeat (3) cycle();
        check("rst_no_done", 64'(obs_done), 64'(0));
        check("rst_idle", 64'(frame_busy), 64'(0));

        // Randomized frames: random valid patterns and random backpressure.
        mode = 1; ready_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int fw = int'($urandom_range(1, 4));
            int fh = int'($urandom_range(1, 3));
            run_frame(fw, fh, -1, 0, -1);
            check("rand_count", 64'(obs_hs), 64'(fw * fh));
            check("rand_done", 64'(obs_done), 64'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
